logo_renderer: RTL and testbench
================================

Name: logo_renderer

Overview:
- Sequential pixel generator that sits between the VGA controller and the logo ROMs (title, game-over, win, press-enter), and feeds the colour mapper.
- Tracks the screen mode and slides the selected logo down from the top at a fixed rate. It addresses the ROMs and blinks the press-enter banner on the title screen.
- Produces registered per-pixel on flags for the colour mapper.

Parameters:
- SCALE_SHIFT, 1: logo magnification exponent, 2x; logo height = 16 << SCALE_SHIFT.
- Y_START, 0: logo top row when a slide begins.
- LOGO_Y, 96: logo top row at rest.
- SLIDE_STEP, 4: rows added to the logo top per frame_tick.
- PRESS_X, 292: press-enter banner left column, 1x scale, 55x5.
- PRESS_Y, 300: press-enter banner top row.
- BLINK_FRAMES, 32: frames on, then frames off, for the banner.

Ports:
- Clk, input, 1: system clock.
- Reset, input, 1: synchronous, active-high reset.
- frame_tick, input, 1: one-cycle pulse per VGA frame.
- mode, input, 2: 0 none, 1 title, 2 game over, 3 win.
- DrawX, input, 10: current pixel column.
- DrawY, input, 10: current pixel row.
- galaga_data, input, 96: title ROM row.
- gameover_data, input, 128: game-over ROM row.
- youwin_data, input, 112: win ROM row.
- press_data, input, 55: press-enter ROM row.
- logo_addr, output, 4: row address to the logo ROMs.
- press_addr, output, 3: row address to the press-enter ROM.
- logo_on, output, 1: logo pixel lit, registered.
- press_on, output, 1: banner pixel lit, registered.
- anim_done, output, 1: logo at rest.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high. All state changes on the rising edge of Clk.
- Reset values: state IDLE; cur_y = Y_START; blink_cnt = 0; mode_q = 0; logo_on = 0; press_on = 0; anim_done = 0.
- State IDLE (mode_q == 0): no pixels lit; anim_done = 0.
- Mode change: mode != mode_q → latch mode_q, cur_y = Y_START, blink_cnt = 0, anim_done = 0; next state is SLIDE if the new mode is nonzero, else IDLE. This applies in every state, including mid-SLIDE, which restarts the slide.
- State SLIDE: on frame_tick, cur_y += SLIDE_STEP.
  - If the result >= LOGO_Y: clamp cur_y to LOGO_Y, go to HOLD, set anim_done = 1 the same edge.
  - Defaults give 24 frame_ticks from entry to HOLD.
- State HOLD: cur_y fixed.
  - On frame_tick, blink_cnt increments, wrapping from 2*BLINK_FRAMES-1 to 0.
  - A mode change and a frame_tick in the same cycle: the mode change wins.
- Logo width W: 96, 128 or 112 for modes 1, 2, 3.
- Logo left column: x0 = 320 - ((W << SCALE_SHIFT) >> 1), giving 224, 192, 208 at defaults.
- Logo hit (combinational): DrawY in [cur_y, cur_y + (16 << SCALE_SHIFT)) and DrawX in [x0, x0 + (W << SCALE_SHIFT)).
  - Use 11-bit compares so no wrap occurs.
- logo_addr = (DrawY - cur_y) >> SCALE_SHIFT, truncated to 4 bits. It is 0 when there is no hit.
- Logo column: col = (DrawX - x0) >> SCALE_SHIFT. Selected bit = data[W-1-col]; the MSB is the leftmost pixel.
- press_addr = DrawY - PRESS_Y when the pixel is in the banner window, else 0.
- Banner pixel bit = press_data[54 - (DrawX - PRESS_X)].
- Banner window and visibility: the window is 55 columns x 5 rows at PRESS_X/PRESS_Y. The banner is visible only when all hold:
  - mode_q == 1;
  - state HOLD;
  - blink_cnt < BLINK_FRAMES.
- Output latency: logo_on and press_on are registered from (hit AND selected bit). They follow DrawX/DrawY by exactly 1 cycle. They are 0 in IDLE and for one cycle after Reset.
- ROM data timing: ROM data is combinational on the address outputs within the same cycle.
- Out-of-range inputs: DrawX/DrawY beyond 639/479 never produce a hit.

Optional Feature:
- Macro LOGO_SLIDE_EN.
- Defined: SLIDE animation as above.
- Undefined:
  - A mode change loads cur_y = LOGO_Y and enters HOLD directly.
  - anim_done = 1 on the edge after the mode change.
  - SLIDE is unreachable.
  - Y_START, SLIDE_STEP unused.

Test Plan:
- Reset asserted 2 cycles with mode = 1 → logo_on = press_on = anim_done = 0. First edge after release: state SLIDE, cur_y = 0.
- mode = 1, 24 frame_ticks (LOGO_SLIDE_EN defined) → anim_done rises on the 24th tick. cur_y = 96 and holds there through 10 more ticks.
- HOLD, mode 1, galaga_data row 2 driven with col 4 = 1 and col 3 = 0:
  - DrawY = 100, DrawX = 232 → logo_addr = 2; logo_on = 1 one cycle later.
  - DrawX = 230 → logo_on = 0.
- HOLD, mode 1, press_data row 0 bit 54 = 1, DrawX = 292, DrawY = 300:
  - press_on = 1 for blink_cnt 0..31, 0 for 32..63, 1 again after 64 ticks.
  - With mode = 2: press_on is always 0.
- Mode 1→3 change at tick 10 of SLIDE → cur_y back to 0, anim_done = 0; logo x0 = 208; HOLD reached 24 ticks later.
- LOGO_SLIDE_EN undefined: mode 0→2 → anim_done = 1 on the next edge. DrawY = 96, DrawX = 192 selects gameover_data[127].

Source files
------------

// File: rtl/logo_renderer.sv
// logo_renderer: tracks the screen mode and slides the selected logo down
// into place. It drives the logo and press-enter ROM row addresses, blinks
// the press-enter banner on the title screen, and registers per-pixel
// lit flags for the colour mapper.
// Optional macro LOGO_SLIDE_EN: when defined, a mode change starts the logo
// at Y_START and slides it down to LOGO_Y. When undefined, the logo appears
// at LOGO_Y immediately and the design holds there.
module logo_renderer #(
  parameter int unsigned SCALE_SHIFT  = 1,
  parameter int unsigned Y_START      = 0,
  parameter int unsigned LOGO_Y       = 96,
  parameter int unsigned SLIDE_STEP   = 4,
  parameter int unsigned PRESS_X      = 292,
  parameter int unsigned PRESS_Y      = 300,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_tick,
  input  logic [1:0]   mode,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  input  logic [95:0]  galaga_data,
  input  logic [127:0] gameover_data,
  input  logic [111:0] youwin_data,
  input  logic [54:0]  press_data,
  output logic [3:0]   logo_addr,
  output logic [2:0]   press_addr,
  output logic         logo_on,
  output logic         press_on,
  output logic         anim_done
);

  localparam int unsigned CW        = 11;
  localparam int unsigned LOGO_H    = 16 << SCALE_SHIFT;
  localparam int unsigned BLINK_W   = $clog2(2 * BLINK_FRAMES);
  localparam int unsigned BLINK_MAX = 2 * BLINK_FRAMES - 1;
  localparam int unsigned PRESS_W   = 55;
  localparam int unsigned PRESS_H   = 5;

  typedef enum logic [1:0] {S_IDLE, S_SLIDE, S_HOLD} state_t;

  state_t               r_state, w_state_nxt;
  logic [9:0]           r_cur_y, w_cur_y_nxt;
  logic [BLINK_W-1:0]   r_blink_cnt, w_blink_nxt;
  logic [1:0]           r_mode_q, w_mode_nxt;
  logic                 w_anim_nxt;
  logic [CW-1:0]        w_y_sum;

  logic [CW-1:0]        w_x, w_y;
  logic                 w_in_screen;
  logic [CW-1:0]        w_logo_w, w_logo_ws, w_x0, w_dx, w_dy;
  logic [127:0]         w_row;
  logic [6:0]           w_col;
  logic                 w_logo_hit, w_logo_bit;
  logic                 w_press_win, w_press_vis, w_press_bit;
  logic [5:0]           w_pdx;
  logic [63:0]          w_press_row;

  assign w_y_sum = CW'(r_cur_y) + CW'(SLIDE_STEP);

  // State, position, blink and mode registers plus the registered pixel flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_cur_y     <= 10'(Y_START);
      r_blink_cnt <= '0;
      r_mode_q    <= 2'd0;
      anim_done   <= 1'b0;
      logo_on     <= 1'b0;
      press_on    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_y     <= w_cur_y_nxt;
      r_blink_cnt <= w_blink_nxt;
      r_mode_q    <= w_mode_nxt;
      anim_done   <= w_anim_nxt;
      logo_on     <= w_logo_hit & w_logo_bit;
      press_on    <= w_press_win & w_press_vis & w_press_bit;
    end
  end

  // Next-state logic; a mode change overrides everything, including a frame_tick
  always_comb begin
    w_state_nxt = r_state;
    w_cur_y_nxt = r_cur_y;
    w_blink_nxt = r_blink_cnt;
    w_mode_nxt  = r_mode_q;
    w_anim_nxt  = anim_done;
    if (mode != r_mode_q) begin
      w_mode_nxt  = mode;
      w_blink_nxt = '0;
`ifdef LOGO_SLIDE_EN
      w_cur_y_nxt = 10'(Y_START);
      w_anim_nxt  = 1'b0;
      w_state_nxt = (mode != 2'd0) ? S_SLIDE : S_IDLE;
`else
      w_cur_y_nxt = 10'(LOGO_Y);
      w_anim_nxt  = (mode != 2'd0);
      w_state_nxt = (mode != 2'd0) ? S_HOLD : S_IDLE;
`endif
    end else begin
      case (r_state)
        S_IDLE: w_anim_nxt = 1'b0;
        S_SLIDE: begin
          if (frame_tick) begin
            if (w_y_sum >= CW'(LOGO_Y)) begin
              w_cur_y_nxt = 10'(LOGO_Y);
              w_state_nxt = S_HOLD;
              w_anim_nxt  = 1'b1;
            end else begin
              w_cur_y_nxt = 10'(w_y_sum);
            end
          end
        end
        S_HOLD: begin
          if (frame_tick)
            w_blink_nxt = (r_blink_cnt == BLINK_W'(BLINK_MAX)) ? '0 : r_blink_cnt + 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Logo width and MSB-aligned ROM row for the latched mode
  always_comb begin
    w_logo_w = '0;
    w_row    = '0;
    case (r_mode_q)
      2'd1: begin w_logo_w = CW'(96);  w_row = {galaga_data, 32'd0};  end
      2'd2: begin w_logo_w = CW'(128); w_row = gameover_data;         end
      2'd3: begin w_logo_w = CW'(112); w_row = {youwin_data, 16'd0};  end
      default: begin w_logo_w = '0;    w_row = '0;                    end
    endcase
  end

  assign w_x         = CW'(DrawX);
  assign w_y         = CW'(DrawY);
  assign w_in_screen = (w_x < CW'(640)) && (w_y < CW'(480));

  assign w_logo_ws  = w_logo_w << SCALE_SHIFT;
  assign w_x0       = CW'(320) - (w_logo_ws >> 1);
  assign w_dx       = w_x - w_x0;
  assign w_dy       = w_y - CW'(r_cur_y);
  assign w_col      = 7'(w_dx >> SCALE_SHIFT);
  assign w_logo_bit = w_row[7'(7'd127 - w_col)];
  assign w_logo_hit = w_in_screen && (r_state != S_IDLE) && (r_mode_q != 2'd0) &&
                      (w_y >= CW'(r_cur_y)) && (w_y < CW'(r_cur_y) + CW'(LOGO_H)) &&
                      (w_x >= w_x0) && (w_x < w_x0 + w_logo_ws);
  assign logo_addr  = w_logo_hit ? 4'(w_dy >> SCALE_SHIFT) : 4'd0;

  assign w_press_win = w_in_screen &&
                       (w_x >= CW'(PRESS_X)) && (w_x < CW'(PRESS_X + PRESS_W)) &&
                       (w_y >= CW'(PRESS_Y)) && (w_y < CW'(PRESS_Y + PRESS_H));
  assign w_press_vis = (r_mode_q == 2'd1) && (r_state == S_HOLD) &&
                       (r_blink_cnt < BLINK_W'(BLINK_FRAMES));
  assign w_pdx       = 6'(w_x - CW'(PRESS_X));
  assign w_press_row = {press_data, 9'd0};
  assign w_press_bit = w_press_row[6'(6'd63 - w_pdx)];
  assign press_addr  = w_press_win ? 3'(w_y - CW'(PRESS_Y)) : 3'd0;

endmodule

// File: tb/tb_logo_renderer.sv
// Directed testbench for logo_renderer at default parameters.
// Honors LOGO_SLIDE_EN the same way the design does.
module tb_logo_renderer;

`ifdef LOGO_SLIDE_EN
  localparam bit SLIDE = 1'b1;
`else
  localparam bit SLIDE = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset, frame_tick;
  logic [1:0]   mode;
  logic [9:0]   DrawX, DrawY;
  logic [95:0]  galaga_data;
  logic [127:0] gameover_data;
  logic [111:0] youwin_data;
  logic [54:0]  press_data;
  logic [3:0]   logo_addr;
  logic [2:0]   press_addr;
  logic         logo_on, press_on, anim_done;

  int errors = 0;
  int checks = 0;

  logo_renderer dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .mode(mode),
    .DrawX(DrawX), .DrawY(DrawY),
    .galaga_data(galaga_data), .gameover_data(gameover_data),
    .youwin_data(youwin_data), .press_data(press_data),
    .logo_addr(logo_addr), .press_addr(press_addr),
    .logo_on(logo_on), .press_on(press_on), .anim_done(anim_done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // In the slide build the logo needs 24 frame_ticks to come to rest
  task automatic settle_slide();
    if (SLIDE) repeat (24) pulse_tick();
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; mode = 2'd1;
    DrawX = '0; DrawY = '0;
    galaga_data = '0; gameover_data = '0; youwin_data = '0; press_data = '0;

    // Reset with mode=1 held
    step(); step();
    chk("rst_logo_on",   32'(logo_on),   32'd0);
    chk("rst_press_on",  32'(press_on),  32'd0);
    chk("rst_anim_done", 32'(anim_done), 32'd0);
    chk("rst_logo_addr", 32'(logo_addr), 32'd0);

    // First edge after release latches mode 1
    Reset = 1'b0;
    DrawX = 10'd224; DrawY = 10'd2;
    step();
    chk("entry_anim_done", 32'(anim_done), SLIDE ? 32'd0 : 32'd1);
    chk("entry_cur_y_addr", 32'(logo_addr), SLIDE ? 32'd1 : 32'd0);

    if (SLIDE) begin
      repeat (23) pulse_tick();
      chk("slide_23_anim", 32'(anim_done), 32'd0);
      pulse_tick();
      chk("slide_24_anim", 32'(anim_done), 32'd1);
      pix(224, 98);
      chk("slide_rest_addr", 32'(logo_addr), 32'd1);
      repeat (10) pulse_tick();
      chk("hold_rest_addr", 32'(logo_addr), 32'd1);
      chk("hold_rest_anim", 32'(anim_done), 32'd1);
      // Restart: 1 -> 3 partway through a slide
      mode = 2'd0; step();
      mode = 2'd1; step();
      repeat (10) pulse_tick();
      mode = 2'd3; step();
      chk("restart_anim", 32'(anim_done), 32'd0);
      pix(208, 2);
      chk("restart_addr", 32'(logo_addr), 32'd1);
      repeat (23) pulse_tick();
      chk("restart_23_anim", 32'(anim_done), 32'd0);
      pulse_tick();
      chk("restart_24_anim", 32'(anim_done), 32'd1);
      mode = 2'd1; step();
      settle_slide();
      pix(224, 2);
      step();
    end

    // Title logo, row 2: col 4 lit, col 3 dark
    galaga_data[91] = 1'b1;
    pix(232, 100);
    chk("t_addr_row2", 32'(logo_addr), 32'd2);
    chk("t_latency_prev", 32'(logo_on), 32'd0);
    step();
    chk("t_col4_on", 32'(logo_on), 32'd1);
    pix(230, 100); step();
    chk("t_col3_off", 32'(logo_on), 32'd0);

    // Title logo horizontal and vertical edges
    galaga_data = '1;
    pix(223, 100); step(); chk("t_left_out",  32'(logo_on), 32'd0);
    pix(224, 100); step(); chk("t_left_in",   32'(logo_on), 32'd1);
    pix(415, 100); step(); chk("t_right_in",  32'(logo_on), 32'd1);
    pix(416, 100); step(); chk("t_right_out", 32'(logo_on), 32'd0);
    pix(300, 127);
    chk("t_bottom_addr", 32'(logo_addr), 32'd15);
    step(); chk("t_bottom_in", 32'(logo_on), 32'd1);
    pix(300, 128);
    chk("t_below_addr", 32'(logo_addr), 32'd0);
    step(); chk("t_below_out", 32'(logo_on), 32'd0);
    pix(300, 95); step(); chk("t_above_out", 32'(logo_on), 32'd0);
    pix(300, 600); step(); chk("t_offscreen", 32'(logo_on), 32'd0);

    // Press-enter banner
    galaga_data = '0;
    press_data = '0; press_data[54] = 1'b1;
    pix(292, 300);
    chk("p_addr0", 32'(press_addr), 32'd0);
    step(); chk("p_on_first", 32'(press_on), 32'd1);
    pix(292, 302);
    chk("p_addr2", 32'(press_addr), 32'd2);
    pix(300, 299);
    chk("p_addr_out", 32'(press_addr), 32'd0);
    press_data = '1;
    pix(291, 300); step(); chk("p_left_out",  32'(press_on), 32'd0);
    pix(346, 304); step(); chk("p_right_in",  32'(press_on), 32'd1);
    pix(347, 300); step(); chk("p_right_out", 32'(press_on), 32'd0);
    pix(300, 305); step(); chk("p_below_out", 32'(press_on), 32'd0);

    // Blink: on for counts 0..31, off for 32..63, on again after wrap
    press_data = '0; press_data[54] = 1'b1;
    pix(292, 300);
    repeat (31) pulse_tick();
    step(); chk("blink_31_on", 32'(press_on), 32'd1);
    pulse_tick();
    step(); chk("blink_32_off", 32'(press_on), 32'd0);
    repeat (31) pulse_tick();
    step(); chk("blink_63_off", 32'(press_on), 32'd0);
    pulse_tick();
    step(); chk("blink_wrap_on", 32'(press_on), 32'd1);
    chk("blink_anim_done", 32'(anim_done), 32'd1);

    // Mode 2 with a simultaneous frame_tick: the mode change wins
    mode = 2'd2; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    settle_slide();
    chk("go_anim_done", 32'(anim_done), 32'd1);
    step(); chk("go_press_off", 32'(press_on), 32'd0);
    repeat (40) pulse_tick();
    step(); chk("go_press_off_late", 32'(press_on), 32'd0);

    // Game-over logo: x0 = 192, MSB is leftmost
    gameover_data = '0; gameover_data[127] = 1'b1;
    pix(192, 96);
    chk("go_addr0", 32'(logo_addr), 32'd0);
    step(); chk("go_msb_on", 32'(logo_on), 32'd1);
    pix(193, 96); step(); chk("go_msb_2x", 32'(logo_on), 32'd1);
    pix(194, 96); step(); chk("go_col1_off", 32'(logo_on), 32'd0);

    // Win logo: x0 = 208, width 224
    mode = 2'd3; step();
    settle_slide();
    youwin_data = '0; youwin_data[111] = 1'b1;
    pix(208, 96); step(); chk("yw_msb_on", 32'(logo_on), 32'd1);
    youwin_data = '1;
    pix(207, 96); step(); chk("yw_left_out",  32'(logo_on), 32'd0);
    pix(431, 96); step(); chk("yw_right_in",  32'(logo_on), 32'd1);
    pix(432, 96); step(); chk("yw_right_out", 32'(logo_on), 32'd0);

    // Back to mode 0: idle, nothing lit
    pix(431, 96);
    mode = 2'd0; step();
    chk("idle_anim_done", 32'(anim_done), 32'd0);
    step();
    chk("idle_logo_on",   32'(logo_on),   32'd0);
    chk("idle_logo_addr", 32'(logo_addr), 32'd0);

    // Synchronous reset mid-operation
    mode = 2'd1; step();
    settle_slide();
    Reset = 1'b1; step();
    chk("rst2_anim_done", 32'(anim_done), 32'd0);
    chk("rst2_logo_on",   32'(logo_on),   32'd0);
    Reset = 1'b0; step();
    chk("rst2_reentry_anim", 32'(anim_done), SLIDE ? 32'd0 : 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
